// File: rtl/vote_pkg.sv
// Shared definitions for the voting session controller.
// Contents: session state enum, default voter count and ballot window
// length, and the count-width helper.
package vote_pkg;

    localparam int unsigned DEF_N_VOTERS = 4;
    localparam int unsigned DEF_TIMEOUT  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_TALLY = 2'd2,
        ST_DONE  = 2'd3
    } vote_state_e;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage : vote_pkg

// File: rtl/vote_popcount.sv
// Combinational population count of an N-bit vector.
// Ports:
//   bits_i  : vector to count
//   count_o : number of set bits in bits_i
module vote_popcount
    import vote_pkg::*;
#(
    parameter int unsigned N  = DEF_N_VOTERS,
    parameter int unsigned CW = count_width(N)
) (
    input  logic [N-1:0]  bits_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule : vote_popcount

// File: rtl/vote_session_ctrl.sv
// Voting session sequencer: opens a ballot window, latches at most one
// ballot per voter, closes when every voter has voted or the window times
// out, then tallies yes/no counts and reports a majority decision.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : open a session (only honoured in IDLE)
//   vote_valid : per-voter ballot strobe
//   vote_yes   : per-voter ballot value, 1 = yes
//   busy       : high while a session is OPEN, in TALLY or DONE
//   voted      : voters whose ballot has been latched
//   done       : one-cycle result strobe
//   yes_cnt    : yes ballots of the last session
//   no_cnt     : no ballots of the last session
//   pass       : decision of the last session
//   timed_out  : last session closed by timeout
//   dup_err    : last session saw a repeat ballot
// Build option: define TIE_CHAIR_EN to let voter 0 break a yes/no tie.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int unsigned N_VOTERS = DEF_N_VOTERS,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [N_VOTERS-1:0]                  vote_valid,
    input  logic [N_VOTERS-1:0]                  vote_yes,
    output logic                                 busy,
    output logic [N_VOTERS-1:0]                  voted,
    output logic                                 done,
    output logic [count_width(N_VOTERS)-1:0]     yes_cnt,
    output logic [count_width(N_VOTERS)-1:0]     no_cnt,
    output logic                                 pass,
    output logic                                 timed_out,
    output logic                                 dup_err
);

    localparam int unsigned CW = count_width(N_VOTERS);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    vote_state_e           state_q;
    logic [N_VOTERS-1:0]   voted_q;
    logic [N_VOTERS-1:0]   ballot_q;
    logic [TW-1:0]         timer_q;
    logic                  busy_q;
    logic                  done_q;
    logic [CW-1:0]         yes_cnt_q;
    logic [CW-1:0]         no_cnt_q;
    logic                  pass_q;
    logic                  timed_out_q;
    logic                  dup_err_q;

    logic [N_VOTERS-1:0]   accept_c;
    logic [N_VOTERS-1:0]   voted_d;
    logic [N_VOTERS-1:0]   ballot_d;
    logic                  dup_hit_c;
    logic [CW-1:0]         yes_c;
    logic [CW-1:0]         no_c;
    logic                  pass_c;

    // Ballot acceptance: first strobe per voter is latched, repeats only flag.
    always_comb begin
        accept_c  = vote_valid & ~voted_q;
        voted_d   = voted_q | vote_valid;
        ballot_d  = (ballot_q & ~accept_c) | (vote_yes & accept_c);
        dup_hit_c = |(vote_valid & voted_q);
    end

    vote_popcount #(.N(N_VOTERS), .CW(CW)) u_pop_yes (
        .bits_i  (voted_q & ballot_q),
        .count_o (yes_c)
    );

    vote_popcount #(.N(N_VOTERS), .CW(CW)) u_pop_no (
        .bits_i  (voted_q & ~ballot_q),
        .count_o (no_c)
    );

    // Strict majority of all voters; abstentions count against.
    always_comb begin
        pass_c = (yes_c > CW'(N_VOTERS / 2));
`ifdef TIE_CHAIR_EN
        if ((yes_c == no_c) && voted_q[0]) begin
            pass_c = ballot_q[0];
        end
`endif
    end

    // Session FSM with timer, ballot and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            voted_q     <= '0;
            ballot_q    <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            yes_cnt_q   <= '0;
            no_cnt_q    <= '0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            dup_err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_OPEN;
                        busy_q      <= 1'b1;
                        voted_q     <= '0;
                        ballot_q    <= '0;
                        timer_q     <= '0;
                        dup_err_q   <= 1'b0;
                        timed_out_q <= 1'b0;
                    end
                end
                ST_OPEN: begin
                    voted_q  <= voted_d;
                    ballot_q <= ballot_d;
                    if (dup_hit_c) begin
                        dup_err_q <= 1'b1;
                    end
                    // Exit is judged on the mask including this edge's ballots.
                    if (&voted_d) begin
                        state_q     <= ST_TALLY;
                        timed_out_q <= 1'b0;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        state_q     <= ST_TALLY;
                        timed_out_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_TALLY: begin
                    yes_cnt_q <= yes_c;
                    no_cnt_q  <= no_c;
                    pass_q    <= pass_c;
                    done_q    <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign voted     = voted_q;
    assign done      = done_q;
    assign yes_cnt   = yes_cnt_q;
    assign no_cnt    = no_cnt_q;
    assign pass      = pass_q;
    assign timed_out = timed_out_q;
    assign dup_err   = dup_err_q;

endmodule : vote_session_ctrl

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl at default parameters
// (4 voters, 16-cycle ballot window).
module tb_vote_session_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] vote_valid;
    logic [3:0] vote_yes;
    logic       busy;
    logic [3:0] voted;
    logic       done;
    logic [2:0] yes_cnt;
    logic [2:0] no_cnt;
    logic       pass;
    logic       timed_out;
    logic       dup_err;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int edges;
    int base;

    vote_session_ctrl #(.N_VOTERS(4), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vote_valid (vote_valid),
        .vote_yes   (vote_yes),
        .busy       (busy),
        .voted      (voted),
        .done       (done),
        .yes_cnt    (yes_cnt),
        .no_cnt     (no_cnt),
        .pass       (pass),
        .timed_out  (timed_out),
        .dup_err    (dup_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done is seen or the budget runs out.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic open_session();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic cast(input logic [3:0] v, input logic [3:0] y);
        vote_valid = v;
        vote_yes   = y;
        step();
        vote_valid = '0;
        vote_yes   = '0;
    endtask

    task automatic check_result(input string tag, input int y, input int n,
                                input bit p, input bit t, input bit d);
        check({tag, "_yes"},   32'(yes_cnt),   32'(y));
        check({tag, "_no"},    32'(no_cnt),    32'(n));
        check({tag, "_pass"},  32'(pass),      32'(p));
        check({tag, "_tout"},  32'(timed_out), 32'(t));
        check({tag, "_dup"},   32'(dup_err),   32'(d));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vote_valid = '0; vote_yes = '0;
        step(); step();
        rst = 1'b0;
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_voted", 32'(voted), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        check_result("rst", 0, 0, 1'b0, 1'b0, 1'b0);

        // All yes in one cycle.
        open_session();
        check("open_busy", 32'(busy), 32'd1);
        cast(4'b1111, 4'b1111);
        wait_done(10, edges);
        check("ayes_lat", 32'(edges), 32'd1);
        check_result("ayes", 4, 0, 1'b1, 1'b0, 1'b0);
        check("ayes_busy_done", 32'(busy), 32'd1);
        step();
        check("ayes_busy_idle", 32'(busy), 32'd0);
        check("ayes_done_low",  32'(done), 32'd0);

        // Tie over two cycles.
        open_session();
        cast(4'b0011, 4'b0011);
        cast(4'b1100, 4'b0000);
        wait_done(10, edges);
`ifdef TIE_CHAIR_EN
        check_result("tie", 2, 2, 1'b1, 1'b0, 1'b0);
`else
        check_result("tie", 2, 2, 1'b0, 1'b0, 1'b0);
`endif
        step();

        // Timeout with voter 3 silent.
        open_session();
        cast(4'b0111, 4'b0111);
        wait_done(40, edges);
        check("tout_lat", 32'(edges + 1), 32'(TIMEOUT + 1));
        check_result("tout", 3, 0, 1'b1, 1'b1, 1'b0);
        check("tout_voted", 32'(voted), 32'b0111);
        step();

        // Last ballot lands on the timeout edge: counts as all-voted.
        open_session();
        cast(4'b0111, 4'b0111);
        repeat (TIMEOUT - 2) step();
        check("edge_busy", 32'(busy), 32'd1);
        cast(4'b1000, 4'b0000);
        wait_done(10, edges);
        check("edge_lat", 32'(edges), 32'd1);
        check_result("edge", 3, 1, 1'b1, 1'b0, 1'b0);
        step();

        // Duplicate ballot from voter 1 is flagged and ignored.
        open_session();
        cast(4'b0010, 4'b0010);
        cast(4'b0010, 4'b0000);
        cast(4'b1101, 4'b0000);
        wait_done(10, edges);
        check_result("dup", 1, 3, 1'b0, 1'b0, 1'b1);
        step();
        open_session();
        check("dup_clr",     32'(dup_err), 32'd0);
        check("dup_keepyes", 32'(yes_cnt), 32'd1);
        cast(4'b1111, 4'b1110);
        wait_done(10, edges);
        check_result("dup2", 3, 1, 1'b1, 1'b0, 1'b0);
        step();

        // Reset in the middle of OPEN.
        open_session();
        cast(4'b0011, 4'b0001);
        base = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_busy",  32'(busy),  32'd0);
        check("mid_voted", 32'(voted), 32'd0);
        check("mid_yes",   32'(yes_cnt), 32'd0);
        repeat (5) step();
        check("mid_nodone", 32'(done_cnt - base), 32'd0);
        open_session();
        cast(4'b1111, 4'b0000);
        wait_done(10, edges);
        check_result("post", 0, 4, 1'b0, 1'b0, 1'b0);
        step();

        // start held through OPEN, TALLY and DONE: one session only.
        base = done_cnt;
        start = 1'b1;
        step();
        vote_valid = 4'b1111; vote_yes = 4'b1111;
        step();
        vote_valid = '0; vote_yes = '0;
        step();
        check("hold_done", 32'(done), 32'd1);
        step();
        start = 1'b0;
        check("hold_busy0", 32'(busy), 32'd0);
        step();
        check("hold_busy1", 32'(busy), 32'd0);
        check("hold_ndone", 32'(done_cnt - base), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_vote_session_ctrl
